dice_roller: RTL

Parametrised multi-die random roller and successor to the single-die 3-bit LFSR roller. Runs entirely on `clk`, with no derived clocks and no roll-edge-clocked flops. A Galois LFSR free-runs at a selectable rate while `roll` is held. On release, one value per die is drawn in `1..SIDES` by rejection sampling with a bounded fallback, and the results are presented with a one-cycle `valid` pulse. The block sits between the debounced roll button and the display/score logic.

---
 rtl/dice_roller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/dice_roller.sv
// dice_roller: multi-die random roller.
// A Galois LFSR steps at a selectable rate while the synchronised roll button
// is held. On release, one face per die is drawn in 1..SIDES by rejection
// sampling with a bounded fallback. The faces appear on die_out together with
// a one-cycle valid pulse.
// Optional feature macro: DICE_SUM_EN adds sum_out, the sum of all faces.
//
// Handshake: valid is a single-cycle strobe with no ready. die_out (and
// sum_out) hold their new value from the valid cycle until the next valid.
// Nothing applies backpressure, so the consumer must take the value on valid
// or read the held copy later.
module dice_roller #(
    parameter int                NUM_DICE  = 2,
    parameter int                SIDES     = 6,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                DIV_FAST  = 2,
    parameter int                DIV_SLOW  = 6,
    parameter int                MAX_TRIES = 4,
    localparam int               CW        = $clog2(SIDES),
    localparam int               OW        = $clog2(SIDES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     roll,
    input  logic                     choice,
    input  logic                     seed_load,
    input  logic [LFSR_W-1:0]        seed,
    output logic [NUM_DICE*OW-1:0]   die_out,
`ifdef DICE_SUM_EN
    output logic [$clog2(NUM_DICE*SIDES+1)-1:0] sum_out,
`endif
    output logic                     valid,
    output logic                     busy,
    output logic [1:0]               dbg_state,
    output logic [LFSR_W-1:0]        dbg_lfsr
);

    localparam int DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
    localparam int DW      = $clog2(DIV_MAX + 1);
    localparam int DIW     = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
    localparam int RW      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [OW-1:0] FACE_ONE = OW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROLL   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_roll_meta;
    logic                      r_roll_s;
    logic [DW-1:0]             r_div_cnt;
    logic [DW-1:0]             w_div_d;
    logic                      w_tick;
    logic [LFSR_W-1:0]         r_lfsr;
    logic [LFSR_W-1:0]         w_lfsr_step;
    logic [LFSR_W-1:0]         w_lfsr_nxt;
    logic [DIW-1:0]            r_d;
    logic [DIW-1:0]            w_d_nxt;
    logic [RW-1:0]             r_try;
    logic [RW-1:0]             w_try_nxt;
    logic [CW-1:0]             w_cand;
    logic                      w_face_we;
    logic [OW-1:0]             w_face_val;
    logic [NUM_DICE*OW-1:0]    r_faces;
    logic [NUM_DICE*OW-1:0]    w_faces_nxt;
    logic [NUM_DICE*OW-1:0]    r_die_out;
    logic                      w_load_out;

    // Bring the asynchronous roll button into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_roll_meta <= 1'b0;
            r_roll_s    <= 1'b0;
        end else begin
            r_roll_meta <= roll;
            r_roll_s    <= r_roll_meta;
        end
    end

    // Free-running step divider; ">=" absorbs a period shrink without a double tick.
    assign w_div_d = choice ? DW'(DIV_FAST) : DW'(DIV_SLOW);
    assign w_tick  = (r_div_cnt >= (w_div_d - DW'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        end
    end

    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    assign w_cand      = r_lfsr[CW-1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, LFSR stepping and per-die accept/reject/fallback decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_d_nxt     = r_d;
        w_try_nxt   = r_try;
        w_face_we   = 1'b0;
        w_face_val  = '0;
        w_load_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_roll_s) begin
                    w_state_nxt = S_ROLL;
                end
            end
            S_ROLL: begin
                if (w_tick) begin
                    w_lfsr_nxt = w_lfsr_step;
                end
                if (!r_roll_s) begin
                    w_state_nxt = S_SAMPLE;
                    w_d_nxt     = '0;
                    w_try_nxt   = '0;
                end
            end
            S_SAMPLE: begin
                w_lfsr_nxt = w_lfsr_step;
                if (int'(w_cand) < SIDES) begin
                    w_face_we  = 1'b1;
                    w_face_val = OW'(int'(w_cand) + 1);
                end else if (r_try < RW'(MAX_TRIES - 1)) begin
                    w_try_nxt = r_try + 1'b1;
                end else begin
                    // 2^CW < 2*SIDES keeps the folded value inside 1..SIDES.
                    w_face_we  = 1'b1;
                    w_face_val = OW'(int'(w_cand) - SIDES + 1);
                end
                if (w_face_we) begin
                    w_d_nxt   = r_d + 1'b1;
                    w_try_nxt = '0;
                    if (r_d == DIW'(NUM_DICE - 1)) begin
                        w_state_nxt = S_DONE;
                        w_load_out  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A seed load wins over any step; zero would lock the LFSR, so use SEED.
        if (seed_load) begin
            w_lfsr_nxt = (seed == '0) ? SEED : seed;
        end
    end

    // Face buffer with the current die's slot overwritten on accept.
    always_comb begin
        w_faces_nxt = r_faces;
        if (w_face_we) begin
            w_faces_nxt[int'(r_d)*OW +: OW] = w_face_val;
        end
    end

    // Datapath registers: LFSR, die index, try count, face buffer, output faces.
    // die_out is loaded on the edge into DONE so it is already new while valid is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr    <= SEED;
            r_d       <= '0;
            r_try     <= '0;
            r_faces   <= {NUM_DICE{FACE_ONE}};
            r_die_out <= {NUM_DICE{FACE_ONE}};
        end else begin
            r_lfsr  <= w_lfsr_nxt;
            r_d     <= w_d_nxt;
            r_try   <= w_try_nxt;
            r_faces <= w_faces_nxt;
            if (w_load_out) begin
                r_die_out <= w_faces_nxt;
            end
        end
    end

`ifdef DICE_SUM_EN
    localparam int SUMW = $clog2(NUM_DICE*SIDES+1);
    logic [SUMW-1:0] w_sum;
    logic [SUMW-1:0] r_sum;

    // Sum of the faces about to be published.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            w_sum = w_sum + SUMW'(w_faces_nxt[i*OW +: OW]);
        end
    end

    // Sum register tracks die_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= SUMW'(NUM_DICE);
        end else if (w_load_out) begin
            r_sum <= w_sum;
        end
    end

    assign sum_out = r_sum;
`endif

    assign die_out   = r_die_out;
    assign valid     = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;
    assign dbg_lfsr  = r_lfsr;

endmodule
